instruction_dispatcher: RTL and testbench
=========================================

INSTRUCTION_DISPATCHER -- requirements
Module: instruction_dispatcher

Interface
REQ-001 Parameter ADDR_W, default `IMEM_ADDR_WIDTH, instruction address and count width.
REQ-002 Parameter INST_W, default 32, instruction word width; bit INST_W-1 is the target-select bit.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 start  input  1  begin dispatching a program; sampled only in IDLE.
REQ-006 instruction_count  input  ADDR_W  number of instructions to issue; latched on accepted start.
REQ-007 imem_rd_en  output  1  instruction memory read strobe.
REQ-008 imem_addr  output  ADDR_W  instruction memory read address.
REQ-009 imem_rd_data  input  INST_W  read data, valid exactly one cycle after imem_rd_en.
REQ-010 pe_inst_valid / pe_inst / pe_inst_ready  output 1 / output INST_W / input 1  PE instruction channel.
REQ-011 buf_inst_valid / buf_inst / buf_inst_ready  output 1 / output INST_W / input 1  buffer instruction channel.
REQ-012 program_counter  output  ADDR_W  count of instructions issued so far in current program.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse on program completion.

Function
REQ-015 FSM states: IDLE, FETCH, CAPTURE, ISSUE, DONE; all outputs are functions of registered state only (Moore).
REQ-016 IDLE + start=1: latch count, clear program_counter to 0; next state FETCH, or DONE if latched count = 0 (no memory read).
REQ-017 IDLE + start=0: remain IDLE; start in any other state is ignored.
REQ-018 FETCH: imem_rd_en=1, imem_addr=program_counter; next state CAPTURE unconditionally.
REQ-019 CAPTURE: imem_rd_en=0; imem_rd_data registered into holding register; next state ISSUE.
REQ-020 ISSUE: holding bit INST_W-1 = 0 -> pe_inst_valid=1; = 1 -> buf_inst_valid=1; never both valids high in the same cycle.
REQ-021 pe_inst and buf_inst both drive the holding register; value stable for the whole ISSUE interval.
REQ-022 Valid held high until the selected channel's ready is high at a rising edge; ready on the non-selected channel is ignored.
REQ-023 Handshake edge: program_counter increments by 1; next state DONE if new value = latched count, else FETCH.
REQ-024 Latency: start edge to first valid = 3 cycles; handshake edge to next valid = 3 cycles; max throughput 1 instruction per 3 cycles.
REQ-025 DONE: done=1, valids=0, program_counter holds final value; next state IDLE.
REQ-026 At DONE entry, program_counter = instruction_count and both valids are low; this is the system completion condition.
REQ-027 Counter widths: program_counter never exceeds latched count (max 2^ADDR_W-1), so no wrap-around occurs.
REQ-028 instruction_count changes after start do not affect the running program.

Reset
REQ-029 rst_n=0 at a rising edge: state IDLE, program_counter=0, latched count=0, holding register=0.
REQ-030 Reset outputs: imem_rd_en=0, imem_addr=0, pe_inst_valid=0, buf_inst_valid=0, pe_inst=buf_inst=0, busy=0, done=0.
REQ-031 Reset mid-ISSUE drops valid on the next edge with no handshake counted; no done pulse is produced.

Verification
REQ-032 count=3, mem={0x0000_0011, 0x8000_0022, 0x0000_0033}, readys tied 1 -> PE gets 0x11, buffer gets 0x8000_0022, PE gets 0x33; first valid 3 cycles after start; done pulses with program_counter=3.
REQ-033 count=1, mem[0]=0x8000_00AA, buf_inst_ready low for 5 cycles -> buf_inst_valid high and buf_inst=0x8000_00AA stable for 6 cycles; pe_inst_valid never high.
REQ-034 count=0, start pulse -> no imem_rd_en, busy high 1 cycle, done pulses 1 cycle after start edge, program_counter=0.
REQ-035 start re-asserted during ISSUE and instruction_count changed 2->7 mid-run -> ignored; exactly 2 instructions issued.
REQ-036 count=4, rst_n low during second ISSUE -> valids low next edge, program_counter=0, done never asserted; subsequent start with count=1 runs correctly.
REQ-037 PE-targeted instruction with buf_inst_ready=1, pe_inst_ready=0 -> no handshake; program_counter unchanged until pe_inst_ready=1.

Source files
------------

// File: rtl/instruction_dispatcher.sv
// Fetches a program from instruction memory and issues each word to the PE or buffer channel by its top bit.
// Latency: 3 cycles from start/handshake to valid; valid and data are held until the selected channel's ready.
`ifndef IMEM_ADDR_WIDTH
`define IMEM_ADDR_WIDTH 8
`endif

module instruction_dispatcher #(
  parameter int ADDR_W = `IMEM_ADDR_WIDTH,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] instruction_count,
  output logic              imem_rd_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rd_data,
  output logic              pe_inst_valid,
  output logic [INST_W-1:0] pe_inst,
  input  logic              pe_inst_ready,
  output logic              buf_inst_valid,
  output logic [INST_W-1:0] buf_inst,
  input  logic              buf_inst_ready,
  output logic [ADDR_W-1:0] program_counter,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_ISSUE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [INST_W-1:0] hold_q, hold_d;
  logic [ADDR_W-1:0] pc_inc;
  logic              sel_buf;
  logic              handshake;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      count_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      hold_q  <= hold_d;
    end
  end

  // Target is chosen by the captured word; the other channel's ready is ignored.
  assign sel_buf   = hold_q[INST_W-1];
  assign handshake = sel_buf ? buf_inst_ready : pe_inst_ready;
  assign pc_inc    = pc_q + ADDR_W'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    hold_d  = hold_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          count_d = instruction_count;
          pc_d    = '0;
          state_d = (instruction_count == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: state_d = S_CAPTURE;
      S_CAPTURE: begin
        hold_d  = imem_rd_data;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (handshake) begin
          pc_d    = pc_inc;
          state_d = (pc_inc == count_q) ? S_DONE : S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_rd_en      = (state_q == S_FETCH);
  assign imem_addr       = pc_q;
  assign pe_inst_valid   = (state_q == S_ISSUE) && !sel_buf;
  assign buf_inst_valid  = (state_q == S_ISSUE) && sel_buf;
  assign pe_inst         = hold_q;
  assign buf_inst        = hold_q;
  assign program_counter = pc_q;
  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_DONE);

endmodule

// File: tb/tb_instruction_dispatcher.sv
// Bench for instruction_dispatcher: directed cases plus randomized programs checked against a
// transaction-level model (expected word order, target, handshake-relative timing).
module tb_instruction_dispatcher;

  localparam int AW = 8;
  localparam int IW = 32;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] instruction_count;
  logic          imem_rd_en;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rd_data;
  logic          pe_inst_valid;
  logic [IW-1:0] pe_inst;
  logic          pe_inst_ready;
  logic          buf_inst_valid;
  logic [IW-1:0] buf_inst;
  logic          buf_inst_ready;
  logic [AW-1:0] program_counter;
  logic          busy;
  logic          done;

  logic [IW-1:0] mem [256];

  int checks = 0;
  int errors = 0;

  instruction_dispatcher #(.ADDR_W(AW), .INST_W(IW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .instruction_count (instruction_count),
    .imem_rd_en        (imem_rd_en),
    .imem_addr         (imem_addr),
    .imem_rd_data      (imem_rd_data),
    .pe_inst_valid     (pe_inst_valid),
    .pe_inst           (pe_inst),
    .pe_inst_ready     (pe_inst_ready),
    .buf_inst_valid    (buf_inst_valid),
    .buf_inst          (buf_inst),
    .buf_inst_ready    (buf_inst_ready),
    .program_counter   (program_counter),
    .busy              (busy),
    .done              (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read memory: data appears one cycle after the read strobe.
  initial imem_rd_data = '0;
  always @(posedge clk) begin
    if (imem_rd_en) imem_rd_data <= mem[imem_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
  endtask

  // Runs one program from IDLE. rdy_pct: random ready probability; hold>0: selected ready low
  // for the first 'hold' valid cycles, other channel's ready high; meddle: poke start/count mid-run.
  task automatic run_program(input int cnt, input int rdy_pct, input int hold, input bit meddle);
    int issued = 0;
    int since = 0;
    int vc = 0;
    int fetches = 0;
    int cyc = 0;
    bit wait_valid = 1'b1;
    bit finished = 1'b0;
    logic [IW-1:0] exp_w;
    logic sel_rdy;
    logic oth_rdy;
    instruction_count = AW'(cnt);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    since = 1;
    while (!finished && cyc < 3000) begin
      check("busy_running", busy, 1);
      check("one_valid_max", pe_inst_valid & buf_inst_valid, 0);
      check("pc_tracks_handshakes", program_counter, issued);
      if (imem_rd_en) begin
        fetches++;
        check("imem_addr", imem_addr, issued);
      end
      if (done) begin
        check("done_issued", issued, cnt);
        check("done_pc", program_counter, cnt);
        check("done_valids_low", {pe_inst_valid, buf_inst_valid}, 0);
        check("done_latency", since, 1);
        check("fetch_count", fetches, cnt);
        finished = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("done_one_cycle", done, 0);
      end else begin
        if (pe_inst_valid || buf_inst_valid) begin
          exp_w = mem[issued];
          if (wait_valid) begin
            check("valid_latency", since, 3);
            wait_valid = 1'b0;
          end
          check("target_buf", buf_inst_valid, exp_w[IW-1]);
          check(exp_w[IW-1] ? "buf_inst" : "pe_inst", exp_w[IW-1] ? buf_inst : pe_inst, exp_w);
          vc++;
          if (hold > 0) begin
            sel_rdy = (vc > hold);
            oth_rdy = 1'b1;
          end else begin
            sel_rdy = ($urandom_range(99) < rdy_pct);
            oth_rdy = $urandom_range(1);
          end
          pe_inst_ready  = exp_w[IW-1] ? oth_rdy : sel_rdy;
          buf_inst_ready = exp_w[IW-1] ? sel_rdy : oth_rdy;
          if (meddle) begin
            start = 1'b1;
            instruction_count = AW'(7);
          end
          if (sel_rdy) begin
            if (hold > 0) check("hold_cycles", vc, hold + 1);
            issued++;
            vc = 0;
            since = 0;
            wait_valid = 1'b1;
          end
        end else begin
          if (!wait_valid) check("valid_dropped", pe_inst_valid | buf_inst_valid, 1);
          pe_inst_ready  = $urandom_range(1);
          buf_inst_ready = $urandom_range(1);
          start = 1'b0;
        end
        @(negedge clk);
        since++;
        cyc++;
      end
    end
    if (!finished) check("program_timeout", finished, 1);
  endtask

  initial begin
    int n;
    int done_seen;
    bit prev_v;
    rst_n = 1'b0;
    start = 1'b0;
    instruction_count = '0;
    pe_inst_ready = 1'b0;
    buf_inst_ready = 1'b0;
    fill_random();
    repeat (3) @(negedge clk);
    check("rst_imem_rd_en", imem_rd_en, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_valids", {pe_inst_valid, buf_inst_valid}, 0);
    check("rst_pe_inst", pe_inst, 0);
    check("rst_buf_inst", buf_inst, 0);
    check("rst_pc", program_counter, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Mixed targets, readys always high.
    mem[0] = 32'h0000_0011;
    mem[1] = 32'h8000_0022;
    mem[2] = 32'h0000_0033;
    run_program(3, 100, 0, 1'b0);

    // Buffer backpressure for 5 cycles.
    mem[0] = 32'h8000_00AA;
    run_program(1, 0, 5, 1'b0);

    // Empty program.
    run_program(0, 100, 0, 1'b0);

    // start/count disturbed mid-run.
    fill_random();
    run_program(2, 70, 0, 1'b1);

    // PE-targeted word while only the buffer is ready.
    mem[0] = 32'h0000_0044;
    run_program(1, 0, 3, 1'b0);

    // Reset during the second issue.
    fill_random();
    pe_inst_ready = 1'b1;
    buf_inst_ready = 1'b1;
    instruction_count = AW'(4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    prev_v = 1'b0;
    for (int c = 0; c < 40 && n < 2; c++) begin
      if ((pe_inst_valid || buf_inst_valid) && !prev_v) n++;
      prev_v = pe_inst_valid | buf_inst_valid;
      if (n < 2) @(negedge clk);
    end
    check("reached_second_issue", n, 2);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valids", {pe_inst_valid, buf_inst_valid}, 0);
    check("midrst_pc", program_counter, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_pe_inst", pe_inst, 0);
    rst_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("midrst_no_done", done_seen, 0);
    run_program(1, 100, 0, 1'b0);

    // Randomized programs.
    for (int p = 0; p < 20; p++) begin
      fill_random();
      run_program($urandom_range(12, 1), $urandom_range(100, 30), 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
